// File: rtl/pipe_ctrl.sv
// pipe_ctrl: stall merging, exception flush/redirect, stall statistics and watchdog
module pipe_ctrl #(
   parameter logic [31:0] EXC_VECTOR = 32'h0000_0020,
   parameter int          WDOG_LIMIT = 1023
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        stallreq_if,
   input  logic        stallreq_id,
   input  logic        stallreq_ex,
   input  logic        stallreq_mem,
   input  logic [31:0] excepttype_i,
   input  logic [31:0] cp0_epc_i,
   input  logic        bus_busy_i,
   output logic [5:0]  stall,
   output logic        flush,
   output logic [31:0] new_pc,
   output logic [31:0] stall_cnt,
   output logic [15:0] flush_cnt,
   output logic        wdog_trip
);
   localparam logic [1:0]  RUN      = 2'd0;
   localparam logic [1:0]  WAIT_BUS = 2'd1;
   localparam logic [1:0]  HOLDOFF  = 2'd2;
   localparam logic [15:0] WLIM     = 16'(WDOG_LIMIT);
   localparam logic [31:0] ERET     = 32'h0000_000e;

   logic [1:0]  state, state_nxt;
   logic [31:0] pend_pc;
   logic [15:0] wdog_cnt, wdog_nxt;
   logic        exc, latch_pc;
   logic [31:0] tgt;
   logic [5:0]  enc;

   assign exc = |excepttype_i;
   assign tgt = (excepttype_i == ERET) ? cp0_epc_i : EXC_VECTOR;
   assign enc = stallreq_mem ? 6'b011111 :
                stallreq_ex ? 6'b001111 :
                (stallreq_id | stallreq_if) ? 6'b000111 : 6'b000000;
   assign latch_pc = !rst && state == RUN && exc && bus_busy_i;
   assign wdog_nxt = (flush || !stall[0]) ? 16'd0 :
                     (wdog_cnt == WLIM) ? wdog_cnt : wdog_cnt + 16'd1;

   // outputs and next state; flush always wins over stall, reset forces everything idle
   always_comb begin
      stall = 6'b000000;
      flush = 1'b0;
      new_pc = 32'd0;
      state_nxt = RUN;
      if (!rst)
         case (state)
            RUN: begin
               flush = exc && !bus_busy_i;
               new_pc = flush ? tgt : 32'd0;
               stall = exc ? (bus_busy_i ? 6'b011111 : 6'b000000) : enc;
               state_nxt = exc ? (bus_busy_i ? WAIT_BUS : HOLDOFF) : RUN;
            end
            WAIT_BUS: begin
               flush = !bus_busy_i;
               new_pc = flush ? pend_pc : 32'd0;
               stall = bus_busy_i ? 6'b011111 : 6'b000000;
               state_nxt = bus_busy_i ? WAIT_BUS : HOLDOFF;
            end
            HOLDOFF: begin
               stall = enc;
               state_nxt = RUN;
            end
            default: state_nxt = RUN;
         endcase
   end

   // state, deferred target, statistics and sticky watchdog flag
   always_ff @(posedge clk) begin
      if (rst) begin
         state <= RUN;
         pend_pc <= 32'd0;
         stall_cnt <= 32'd0;
         flush_cnt <= 16'd0;
         wdog_cnt <= 16'd0;
         wdog_trip <= 1'b0;
      end else begin
         state <= state_nxt;
         pend_pc <= latch_pc ? tgt : pend_pc;
         stall_cnt <= stall_cnt + 32'(stall[0]);
         flush_cnt <= flush_cnt + 16'(flush);
         wdog_cnt <= wdog_nxt;
         wdog_trip <= wdog_trip | (wdog_nxt == WLIM);
      end
   end
endmodule

// File: tb/tb_pipe_ctrl.sv
// tb_pipe_ctrl: directed and randomized checks of pipe_ctrl against a behavioural model
module tb_pipe_ctrl;
   localparam int LIM = 4;
   logic        clk = 0, rst;
   logic        stallreq_if, stallreq_id, stallreq_ex, stallreq_mem, bus_busy_i;
   logic [31:0] excepttype_i, cp0_epc_i;
   logic [5:0]  stall;
   logic        flush, wdog_trip;
   logic [31:0] new_pc, stall_cnt;
   logic [15:0] flush_cnt;
   int total = 0, bad = 0;

   // model: pending deferred exception, one-cycle mask after a flush, counters
   bit          m_pend, m_mask, m_trip;
   logic [31:0] m_ppc, m_scnt;
   logic [15:0] m_fcnt;
   int          m_wd;

   pipe_ctrl #(.EXC_VECTOR(32'h0000_0020), .WDOG_LIMIT(LIM)) dut (
      .clk(clk), .rst(rst), .stallreq_if(stallreq_if), .stallreq_id(stallreq_id),
      .stallreq_ex(stallreq_ex), .stallreq_mem(stallreq_mem), .excepttype_i(excepttype_i),
      .cp0_epc_i(cp0_epc_i), .bus_busy_i(bus_busy_i), .stall(stall), .flush(flush),
      .new_pc(new_pc), .stall_cnt(stall_cnt), .flush_cnt(flush_cnt), .wdog_trip(wdog_trip));

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
      end
   endtask

   task automatic cyc(input bit r, input bit sif, input bit sid, input bit sex, input bit smem,
                      input logic [31:0] exc, input logic [31:0] epc, input bit busy);
      logic [5:0]  e_st;
      logic [31:0] e_pc, tgt;
      bit          e_fl, take;
      int          n;
      rst = r; stallreq_if = sif; stallreq_id = sid; stallreq_ex = sex; stallreq_mem = smem;
      excepttype_i = exc; cp0_epc_i = epc; bus_busy_i = busy;
      #1;
      tgt = (exc == 32'he) ? epc : 32'h20;
      take = !r && !m_pend && !m_mask && exc != 0;
      n = smem ? 5 : sex ? 4 : (sid || sif) ? 3 : 0;
      e_fl = 0; e_pc = 0; e_st = 0;
      if (r) ;
      else if (m_pend || take) begin
         e_fl = !busy;
         e_pc = e_fl ? (m_pend ? m_ppc : tgt) : 0;
         e_st = e_fl ? 6'd0 : 6'b011111;
      end else e_st = 6'((1 << n) - 1);
      chk("stall", 32'(stall), 32'(e_st));
      chk("flush", 32'(flush), 32'(e_fl));
      chk("new_pc", new_pc, e_pc);
      @(posedge clk);
      if (r) begin
         m_pend = 0; m_mask = 0; m_trip = 0; m_ppc = 0; m_scnt = 0; m_fcnt = 0; m_wd = 0;
      end else begin
         if (take && busy) m_ppc = tgt;
         m_pend = m_pend ? busy : (take && busy);
         m_mask = e_fl;
         m_scnt += 32'(e_st[0]);
         m_fcnt += 16'(e_fl);
         m_wd = (e_fl || !e_st[0]) ? 0 : (m_wd == LIM ? m_wd : m_wd + 1);
         if (m_wd == LIM) m_trip = 1;
      end
      #1;
      chk("stall_cnt", stall_cnt, m_scnt);
      chk("flush_cnt", 32'(flush_cnt), 32'(m_fcnt));
      chk("wdog_trip", 32'(wdog_trip), 32'(m_trip));
      @(negedge clk);
   endtask

   initial begin
      @(negedge clk);
      cyc(1, 0, 0, 0, 0, 0, 0, 0);
      cyc(1, 1, 1, 1, 1, 32'h8, 0, 0);
      chk("rst_cnt", stall_cnt, 0);
      // priority
      cyc(0, 0, 1, 0, 1, 0, 0, 0);
      cyc(0, 0, 1, 0, 0, 0, 0, 0);
      cyc(0, 0, 0, 0, 0, 0, 0, 0);
      chk("pri_cnt", stall_cnt, 2);
      // exception, bus idle
      cyc(0, 0, 0, 0, 0, 32'h8, 0, 0);
      cyc(0, 0, 0, 0, 0, 0, 0, 0);
      chk("exc_fcnt", 32'(flush_cnt), 1);
      // eret
      cyc(0, 0, 0, 0, 0, 32'he, 32'h1234, 0);
      cyc(0, 0, 0, 0, 0, 0, 0, 0);
      // deferred exception
      cyc(0, 0, 0, 0, 0, 32'hc, 0, 1);
      cyc(0, 0, 0, 0, 0, 0, 0, 1);
      cyc(0, 0, 0, 0, 0, 0, 0, 1);
      cyc(0, 0, 0, 0, 0, 0, 0, 0);
      cyc(0, 0, 0, 0, 0, 0, 0, 0);
      // holdoff masking after reset
      cyc(1, 0, 0, 0, 0, 0, 0, 0);
      cyc(0, 0, 0, 0, 0, 32'h4, 0, 0);
      cyc(0, 0, 0, 0, 0, 32'h4, 0, 0);
      cyc(0, 0, 0, 0, 0, 0, 0, 0);
      chk("hold_fcnt", 32'(flush_cnt), 1);
      // watchdog then reset
      repeat (LIM) cyc(0, 0, 0, 1, 0, 0, 0, 0);
      chk("wdog_set", 32'(wdog_trip), 1);
      cyc(0, 0, 0, 0, 0, 0, 0, 0);
      chk("wdog_hold", 32'(wdog_trip), 1);
      cyc(1, 0, 0, 0, 0, 0, 0, 0);
      chk("rst_trip", 32'(wdog_trip), 0);
      chk("rst_fcnt", 32'(flush_cnt), 0);
      // reset while waiting on the bus drops the pending exception
      cyc(0, 0, 0, 0, 0, 32'h8, 0, 1);
      cyc(1, 0, 0, 0, 0, 0, 0, 1);
      cyc(0, 0, 0, 0, 0, 0, 0, 0);
      chk("rst_wait", 32'(flush_cnt), 0);
      // random
      for (int i = 0; i < 600; i++) begin
         logic [31:0] e;
         e = ($urandom_range(0, 5) == 0) ? (($urandom_range(0, 1) == 0) ? 32'he : 32'($urandom_range(1, 31))) : 32'd0;
         cyc($urandom_range(0, 99) == 0, $urandom_range(0, 3) == 0, $urandom_range(0, 3) == 0,
             $urandom_range(0, 2) == 0, $urandom_range(0, 3) == 0, e, $urandom,
             $urandom_range(0, 2) == 0);
      end
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule

// File: doc/pipe_ctrl.md
# pipe_ctrl

Pipeline control unit for the five-stage OpenMIPS core. It merges per-stage stall requests into the `stall[5:0]` vector and issues the one-cycle `flush` and `new_pc` that redirect fetch on an exception or `eret`. Exceptions that arrive while a bus transaction is in flight are deferred until the bus goes idle. The block also keeps stall and flush statistics and a stall watchdog. It drives the stall and flush inputs of every pipeline register (if_id, id_ex, ex_mem, mem_wb) and the PC register.

## Interface
- EXC_VECTOR, 32'h0000_0020, target PC for every exception except `eret`
- WDOG_LIMIT, 1023, number of consecutive stalled cycles at which the watchdog trips (range 1..65535)
- clk  in  1  clock
- rst  in  1  synchronous, active-high reset
- stallreq_if  in  1  instruction fetch is waiting on the bus
- stallreq_id  in  1  load-use hazard in decode
- stallreq_ex  in  1  multi-cycle EX operation (div, madd/msub)
- stallreq_mem  in  1  data access is waiting on the bus
- excepttype_i  in  32  exception code from MEM; nonzero means an exception is present; 32'h0000_000e means `eret`
- cp0_epc_i  in  32  current CP0 EPC value
- bus_busy_i  in  1  an instruction or data bus transaction is outstanding and cannot be aborted
- stall  out  6  bit0 PC, bit1 IF, bit2 ID, bit3 EX, bit4 MEM, bit5 WB; 1 means hold
- flush  out  1  clear all pipeline registers at the next edge
- new_pc  out  32  redirect PC; valid only while flush=1
- stall_cnt  out  32  count of cycles with stall[0]=1
- flush_cnt  out  16  count of flush pulses
- wdog_trip  out  1  sticky flag: the watchdog limit was reached

## Operation
- States: RUN, WAIT_BUS, HOLDOFF.
- Stall encoding, applied in RUN when there is no exception, in priority order:
  - stallreq_mem: 6'b011111
  - else stallreq_ex: 6'b001111
  - else stallreq_id or stallreq_if: 6'b000111
  - else 6'b000000
- RUN with excepttype_i≠0 and bus_busy_i=0:
  - flush=1, stall=0
  - new_pc = cp0_epc_i if excepttype_i==32'h0000_000e, else EXC_VECTOR
  - next state HOLDOFF
- RUN with excepttype_i≠0 and bus_busy_i=1:
  - latch the target PC, computed with the same rule, into pend_pc
  - stall=6'b011111, flush=0
  - next state WAIT_BUS
- WAIT_BUS:
  - excepttype_i is ignored; stall=6'b011111
  - when bus_busy_i=0: flush=1, stall=0, new_pc=pend_pc, next state HOLDOFF
- HOLDOFF (exactly 1 cycle):
  - excepttype_i is ignored
  - stall follows the stall encoding; flush=0
  - next state RUN
- Flush overrides stall in every state. A stall request in the same cycle as flush is dropped.
- new_pc=0 whenever flush=0.
- stall_cnt increments every cycle in which the stall output has bit0=1. It wraps modulo 2^32.
- flush_cnt increments on every flush cycle. It wraps modulo 2^16.
- Watchdog:
  - 16-bit counter, incremented each cycle with stall[0]=1, cleared on any cycle with stall[0]=0 or flush=1
  - saturates at WDOG_LIMIT
  - when the counter reaches WDOG_LIMIT, wdog_trip is set and stays set until rst
  - pipeline behaviour is unchanged when the watchdog trips

## Timing
- stall, flush and new_pc are combinational from the current state and inputs. The pipeline registers sample them at the next posedge.
- Exception to flush latency: 0 cycles when the bus is idle. Otherwise flush is asserted in the first cycle with bus_busy_i=0.
- State, pend_pc, counters and wdog_trip update on posedge clk.
- While rst=1:
  - stall=0, flush=0, new_pc=0
  - state=RUN, pend_pc=0, stall_cnt=0, flush_cnt=0, watchdog counter=0, wdog_trip=0
- rst asserted in WAIT_BUS discards the pending exception. No flush is issued after rst.
- An exception in the same cycle as stallreq_mem is handled as an exception: the stall encoding is not applied.
- Back-to-back exceptions: the second is accepted no earlier than 2 cycles after the first flush, because HOLDOFF masks one cycle.

## Test plan
- Priority: stallreq_id=1 and stallreq_mem=1 in the same cycle -> stall=6'b011111. Drop stallreq_mem -> stall=6'b000111. Release all requests -> stall=0. stall_cnt=2.
- Exception, bus idle: excepttype_i=32'h0000_0008 with bus_busy_i=0 -> same-cycle flush=1, new_pc=32'h0000_0020, stall=0. Next cycle flush=0. flush_cnt=1.
- eret: excepttype_i=32'h0000_000e, cp0_epc_i=32'h0000_1234 -> flush=1, new_pc=32'h0000_1234.
- Deferred exception: excepttype_i=32'h0000_000c with bus_busy_i=1 for 3 cycles, excepttype_i driven to 0 after the first cycle -> stall=6'b011111 for 3 cycles, then one cycle with flush=1 and new_pc=32'h0000_0020.
- HOLDOFF masking: excepttype_i held nonzero for 2 cycles -> exactly one flush pulse. flush_cnt=1.
- Watchdog and reset: with WDOG_LIMIT=4, hold stallreq_ex for 4 cycles -> wdog_trip=1 and stays 1 after stalls end. Assert rst for 1 cycle -> all outputs and counters return to 0.
